// File: rtl/core_sequencer.sv
// Address sequencer for the calculator core: issues a programmed address range on Counter
// and tags the core's fixed-latency results. Define SEQ_LOOP_EN to repeat the range until stopped.
module core_sequencer #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int PIPE_LATENCY  = 3
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Pause,
    input  logic [ADDRESS_WIDTH-1:0] Start_Address,
    input  logic [ADDRESS_WIDTH-1:0] End_Address,
    output logic [ADDRESS_WIDTH-1:0] Counter,
    output logic                     Issue,
    output logic                     Busy,
    output logic                     Result_Valid,
    output logic [ADDRESS_WIDTH-1:0] Result_Index,
    output logic                     Done,
    output logic                     Error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     state;
    logic [ADDRESS_WIDTH-1:0]   end_lat;
`ifdef SEQ_LOOP_EN
    logic [ADDRESS_WIDTH-1:0]   start_lat;
    logic                       stop_req;
`endif

    logic [PIPE_LATENCY-1:0]    vld_p;
    logic [ADDRESS_WIDTH-1:0]   idx_p [PIPE_LATENCY];
    logic [PIPE_LATENCY-1:0]    vld_adv;

    logic range_ok;
    logic at_end;
    logic pending;

    assign range_ok = (Start_Address <= End_Address);
    assign at_end   = Issue && (Counter == end_lat);
    // Tags that will still reach the last stage after this edge; the
    // last-stage tag is being presented now and needs no further wait.
    assign vld_adv  = vld_p << 1;
    assign pending  = |vld_adv;

    assign Result_Valid = vld_p[PIPE_LATENCY-1];
    assign Result_Index = idx_p[PIPE_LATENCY-1];

    // Tag pipeline: mirrors the core's latency, stage 0 captures {Issue, Counter}
    always_ff @(posedge CLK) begin
        if (Reset) begin
            vld_p <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                idx_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= Issue;
            idx_p[0] <= Counter;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                idx_p[i] <= idx_p[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= S_IDLE;
            Counter <= '0;
            Issue   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
            end_lat <= '0;
`ifdef SEQ_LOOP_EN
            start_lat <= '0;
            stop_req  <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    Issue <= 1'b0;
                    if (Start) begin
                        if (range_ok) begin
                            end_lat <= End_Address;
`ifdef SEQ_LOOP_EN
                            start_lat <= Start_Address;
                            stop_req  <= 1'b0;
`endif
                            Counter <= Start_Address;
                            Issue   <= 1'b1;
                            Error   <= 1'b0;
                            Busy    <= 1'b1;
                            state   <= S_RUN;
                        end else begin
                            Error <= 1'b1;
                            Done  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
`ifdef SEQ_LOOP_EN
                    if (Start) begin
                        stop_req <= 1'b1;
                    end
`endif
                    if (at_end) begin
`ifdef SEQ_LOOP_EN
                        // A stop request lets the current pass finish up to End.
                        if (stop_req || Start) begin
                            Issue <= 1'b0;
                            state <= S_DRAIN;
                        end else begin
                            Counter <= start_lat;
                            Issue   <= ~Pause;
                        end
`else
                        Issue <= 1'b0;
                        state <= S_DRAIN;
`endif
                    end else begin
                        if (Issue) begin
                            Counter <= Counter + 1'b1;
                        end
                        Issue <= ~Pause;
                    end
                end

                S_DRAIN: begin
                    Issue <= 1'b0;
                    if (!pending) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    Issue <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    Issue <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Address sequencer directly upstream of the calculator pipeline core; drives the core's Counter input.
- Steps through a programmed instruction-memory address range and supports pause.
- Tracks which addresses are in flight through the core's fixed-latency pipeline. Produces Result_Valid/Result_Index aligned with the core's Result output.
- Signals completion once the last result has emerged.

Parameters:
- ADDRESS_WIDTH, 10, width of instruction-memory address / Counter.
- PIPE_LATENCY, 3, cycles from Counter presenting an address to the core's Result for that address.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle request to run a range; honoured only in IDLE.
- Pause  input  1  level; suppresses issue of new addresses while high.
- Start_Address  input  ADDRESS_WIDTH  first address of range; sampled on accepted Start.
- End_Address  input  ADDRESS_WIDTH  last address of range, inclusive; sampled on accepted Start.
- Counter  output  ADDRESS_WIDTH  address fed to core; registered.
- Issue  output  1  Counter holds a newly issued address this cycle; registered.
- Busy  output  1  high in RUN and DRAIN.
- Result_Valid  output  1  core Result this cycle belongs to an issued address.
- Result_Index  output  ADDRESS_WIDTH  address whose result is on core Result.
- Done  output  1  one-cycle pulse at end of run.
- Error  output  1  range rejected; held until next accepted Start or Reset.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - state=IDLE; Counter=0; Issue=0; Busy=0; Done=0; Error=0.
  - All in-flight valid bits cleared, so Result_Valid=0 next cycle.
  - Result_Index=0.
  - Reset mid-run abandons the run; no Done is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Start=1 with Start_Address<=End_Address: latch End_Address; Counter<=Start_Address; Issue<=1; Error<=0; go RUN.
  - Start=1 with Start_Address>End_Address: Error<=1; Done<=1 for one cycle; stay IDLE; nothing issued.
  - Otherwise Counter holds, Issue=0.
- RUN, evaluated at each edge:
  - Issue=1 and Counter==latched End: Issue<=0, Counter holds, go DRAIN.
  - Issue=1 and Counter!=End: Counter<=Counter+1; Issue<=~Pause.
  - Issue=0 (paused): Counter holds; Issue<=~Pause.
  - Pause sampled high at edge k therefore gives Issue=0 from cycle k+1. Each address is issued exactly once, in ascending order.
  - Start is ignored in RUN, DRAIN and DONE.
- Pause in IDLE or DRAIN has no effect.
- Range Start_Address==End_Address: exactly one address is issued.
- No Counter wrap-around: the End bound always precedes overflow. End_Address=2^ADDRESS_WIDTH-1 is legal.
- Valid tracking:
  - PIPE_LATENCY-deep shift register of {valid, index}, fed each cycle with {Issue, Counter}.
  - The last stage drives Result_Valid/Result_Index.
  - If Issue=1 with Counter=A in cycle c, then Result_Valid=1 with Result_Index=A in cycle c+PIPE_LATENCY.
  - Paused cycles insert bubbles (valid=0); the core still recomputes the held address, but that result is untagged.
- DRAIN: go DONE when all shift-register valid bits are 0, i.e. the last result has already been presented.
- DONE: Done=1 for one cycle; Busy=0; go IDLE.
- Busy=1 exactly in RUN and DRAIN.
- Done is never asserted together with Result_Valid.

Optional Feature:
- Macro SEQ_LOOP_EN.
- When defined: in RUN, when Issue=1 and Counter==End:
  - Counter<=latched Start_Address and Issue<=~Pause; stay in RUN.
  - The sequence runs continuously until Start is asserted while Busy. That Start acts as a stop request: finish the current address, then go DRAIN as if End were reached.
  - Done fires after the drain.
- Start_Address is latched alongside End_Address.
- When undefined: behaviour exactly as above. Start while Busy is ignored and the Start_Address latch is not synthesised.

Test Plan:
- Reset, Start with Start_Address=5, End_Address=8, Pause=0:
  - Counter 5,6,7,8 with Issue=1 on consecutive cycles.
  - Result_Valid with Result_Index 5,6,7,8 three cycles later.
  - Done pulse one cycle after index 8; Busy low thereafter.
- Start_Address=End_Address=12 → one issue of 12; one Result_Valid with index 12; Done; Error=0.
- Start_Address=9, End_Address=3 → Error=1; Done pulse the next cycle; Issue never high; Busy stays 0.
- Range 0..5, Pause high for 2 cycles while Counter=2 is issued:
  - Counter holds 3 with Issue=0 for 2 cycles, then 3,4,5 issued.
  - Result_Index stream is 0,1,2,bubble,bubble,3,4,5; no duplicates.
- Reset asserted during RUN at Counter=40 (range 32..63):
  - Next cycle Counter=0, Issue=0, Busy=0, Result_Valid=0; no Done.
  - A Start afterwards runs normally.
- With SEQ_LOOP_EN, range 1..3: Counter sequence 1,2,3,1,2,3,… Start while Busy during Counter=2 → issues 2,3 then DRAIN; Done after index 3 emerges.
